im_frame_fifo: RTL and testbench

Parametrised frame buffer between the AXI-stream image source and the user readout logic. It stores incoming words and releases them to the reader only in whole frames of FRAME_LEN words. It reports how many complete frames are waiting and optionally enforces tlast framing, discarding malformed frames. Supersedes the fixed 32-bit "ready when full" image FIFO.

---
 rtl/im_fifo_pkg.sv | 28 ++
 rtl/im_fifo_ram.sv | 55 +++++
 rtl/im_frame_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_im_frame_fifo.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_fifo_pkg.sv
// im_fifo_pkg
// Shared definitions for the frame FIFO: the write-side state enum and
// helper functions that derive pointer, word-index and frame-count widths
// from the FIFO geometry.
package im_fifo_pkg;

   typedef enum logic {
      ST_WRITE   = 1'b0,
      ST_DISCARD = 1'b1
   } state_t;

   // Pointer width: one extra bit beyond the address so full and empty
   // are distinguishable with naturally wrapping pointers.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Width of the word-within-frame index.
   function automatic int idx_w(input int frame_len);
      return $clog2(frame_len);
   endfunction

   // Width of the committed-frame counter (must be able to hold depth/frame_len).
   function automatic int frames_w(input int depth, input int frame_len);
      return $clog2(depth / frame_len) + 1;
   endfunction

endpackage

// File: rtl/im_fifo_ram.sv
// im_fifo_ram
// Simple dual-port RAM, DATA_W x DEPTH, synchronous write and registered
// read. The read register resets to 0 and is also cleared by clr.
// Ports:
//   clk, rst        clock, asynchronous active-low reset of the read register
//   clr             synchronous clear of the read register
//   wr_en/addr/data write port
//   rd_en/addr      read request; rd_data updates on the next edge
//   rd_data         registered read data
module im_fifo_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   // Storage array has no reset; only the output register does.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (clr) begin
         rd_data_d = '0;
      end else if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/im_frame_fifo.sv
// im_frame_fifo
// Frame buffer between an AXI-stream image source and a reader. Words are
// stored as they arrive but only become readable once a whole frame of
// FRAME_LEN words has been received (committed).
//
// Optional feature macro: IM_FIFO_TLAST_CHECK_EN
//   defined   - tlast must arrive exactly on the last word of each frame;
//               malformed frames are rewound and len_err is set.
//   undefined - tlast is ignored, frames commit by word count only.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   flush              synchronous clear of all contents and state
//   s_axis_*           stream input (tdata, tlast, tvalid, tready)
//   rd_en              read request for the next committed word
//   rd_data/rd_valid   registered read data, one cycle after rd_en
//   frame_ready        at least one committed frame stored
//   frames_avail       committed frames not yet fully read
//   fill_level         words stored, committed and uncommitted
//   len_err            sticky framing error
//
// Handshake: a stream word transfers on a rising edge where tvalid and tready
// are both high; tready never depends on tvalid, and tdata/tlast are only
// looked at on transferring edges.
module im_frame_fifo
   import im_fifo_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 512,
   parameter int FRAME_LEN = 256
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [DATA_W-1:0]                    s_axis_tdata,
   input  logic                                 s_axis_tlast,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic                                 rd_en,
   output logic [DATA_W-1:0]                    rd_data,
   output logic                                 rd_valid,
   output logic                                 frame_ready,
   output logic [frames_w(DEPTH, FRAME_LEN)-1:0] frames_avail,
   output logic [ptr_w(DEPTH)-1:0]              fill_level,
   output logic                                 len_err
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam int IW = idx_w(FRAME_LEN);
   localparam int FW = frames_w(DEPTH, FRAME_LEN);

   localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
   localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

   logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
   logic [IW-1:0] idx_q,        idx_d;
   logic [FW-1:0] frames_q,     frames_d;
   logic          len_err_q,    len_err_d;
   logic          rd_valid_q,   rd_valid_d;
   state_t        state_q,      state_d;

   logic [PW-1:0] used;
   logic          full;
   logic          accept;
   logic          rd_fire;
   logic          frame_done;
   logic          ram_we;
   logic          commit;
   logic          bad_early;
   logic          bad_late;

   assign used = wr_ptr_q - rd_ptr_q;
   assign full = (used == PTR_DEPTH);

   // While discarding, words are dropped rather than stored, so fullness
   // must not stall the source.
   assign s_axis_tready = ~flush & ((state_q == ST_DISCARD) | ~full);
   assign accept        = s_axis_tvalid & s_axis_tready;

   // Only committed words are readable; flush wins over a pending read.
   assign rd_fire    = rd_en & ~flush & (rd_ptr_q != commit_ptr_q);
   // FRAME_LEN is a power of two, so the low read-pointer bits give the
   // position within the frame being read.
   assign frame_done = rd_fire & (rd_ptr_q[IW-1:0] == IDX_LAST);

`ifdef IM_FIFO_TLAST_CHECK_EN
   assign bad_early = s_axis_tlast & (idx_q != IDX_LAST);
   assign bad_late  = ~s_axis_tlast & (idx_q == IDX_LAST);
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
   assign bad_early    = 1'b0;
   assign bad_late     = 1'b0;
`endif

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      idx_d        = idx_q;
      frames_d     = frames_q;
      len_err_d    = len_err_q;
      state_d      = state_q;
      rd_valid_d   = rd_fire;
      ram_we       = 1'b0;
      commit       = 1'b0;

      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      if (accept) begin
         if (state_q == ST_DISCARD) begin
`ifdef IM_FIFO_TLAST_CHECK_EN
            if (s_axis_tlast) begin
               state_d = ST_WRITE;
            end
`endif
         end else if (bad_early || bad_late) begin
            // Drop the partial frame by rewinding to the last commit point.
            wr_ptr_d  = commit_ptr_q;
            idx_d     = '0;
            len_err_d = 1'b1;
            if (bad_late) begin
               state_d = ST_DISCARD;
            end
         end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (idx_q == IDX_LAST) begin
               commit       = 1'b1;
               commit_ptr_d = wr_ptr_q + PW'(1);
               idx_d        = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
      end

      case ({commit, frame_done})
         2'b10:   frames_d = frames_q + FW'(1);
         2'b01:   frames_d = frames_q - FW'(1);
         default: frames_d = frames_q;
      endcase

      if (flush) begin
         wr_ptr_d     = '0;
         commit_ptr_d = '0;
         rd_ptr_d     = '0;
         idx_d        = '0;
         frames_d     = '0;
         len_err_d    = 1'b0;
         rd_valid_d   = 1'b0;
         state_d      = ST_WRITE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         idx_q        <= '0;
         frames_q     <= '0;
         len_err_q    <= 1'b0;
         rd_valid_q   <= 1'b0;
         state_q      <= ST_WRITE;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         idx_q        <= idx_d;
         frames_q     <= frames_d;
         len_err_q    <= len_err_d;
         rd_valid_q   <= rd_valid_d;
         state_q      <= state_d;
      end
   end

   im_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (s_axis_tdata),
      .rd_en   (rd_fire),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (rd_data)
   );

   assign rd_valid     = rd_valid_q;
   assign frames_avail = frames_q;
   assign frame_ready  = (frames_q != '0);
   assign fill_level   = used;
   assign len_err      = len_err_q;

endmodule

// File: tb/tb_im_frame_fifo.sv
// tb_im_frame_fifo
// Directed bench for im_frame_fifo (DATA_W=32, DEPTH=16, FRAME_LEN=4).
// A queue-based model of committed and pending words predicts every output
// each cycle; directed scenarios add literal expectations on top.
// Scenarios depending on tlast checking follow IM_FIFO_TLAST_CHECK_EN.
module tb_im_frame_fifo;

   localparam int DATA_W    = 32;
   localparam int DEPTH     = 16;
   localparam int FRAME_LEN = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        rd_en = 1'b0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        frame_ready;
   logic [2:0]  frames_avail;
   logic [4:0]  fill_level;
   logic        len_err;

   always #5 clk = ~clk;

   im_frame_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .frame_ready   (frame_ready),
      .frames_avail  (frames_avail),
      .fill_level    (fill_level),
      .len_err       (len_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] exp_q[$];   // committed, unread words in read order
   logic [31:0] pend_q[$];  // accepted words of the frame being received
   logic [31:0] got_q[$];   // words actually delivered by the DUT
   logic        m_discard  = 1'b0;
   logic        m_len_err  = 1'b0;
   logic        m_rd_valid = 1'b0;
   logic [31:0] m_rd_data  = '0;

   function automatic int m_fill();
      return exp_q.size() + pend_q.size();
   endfunction

   function automatic int m_frames();
      return (exp_q.size() + FRAME_LEN - 1) / FRAME_LEN;
   endfunction

   function automatic logic m_tready();
      if (flush) return 1'b0;
      if (m_discard) return 1'b1;
      return (m_fill() < DEPTH);
   endfunction

   task automatic model_clear();
      exp_q.delete();
      pend_q.delete();
      m_discard  = 1'b0;
      m_len_err  = 1'b0;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
   endtask

   task automatic model_push(input logic [31:0] d);
      pend_q.push_back(d);
      if (pend_q.size() == FRAME_LEN) begin
         foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
         pend_q.delete();
      end
   endtask

   task automatic model_step();
      logic acc;
      logic rd;
      acc = s_axis_tvalid && m_tready();
      rd  = rd_en && !flush && (exp_q.size() > 0);
      if (flush) begin
         model_clear();
         return;
      end
      m_rd_valid = rd;
      if (rd) m_rd_data = exp_q.pop_front();
      if (acc) begin
         if (m_discard) begin
            if (s_axis_tlast) m_discard = 1'b0;
         end else begin
`ifdef IM_FIFO_TLAST_CHECK_EN
            if (s_axis_tlast && pend_q.size() < FRAME_LEN - 1) begin
               pend_q.delete();
               m_len_err = 1'b1;
            end else if (!s_axis_tlast && pend_q.size() == FRAME_LEN - 1) begin
               pend_q.delete();
               m_len_err = 1'b1;
               m_discard = 1'b1;
            end else begin
               model_push(s_axis_tdata);
            end
`else
            model_push(s_axis_tdata);
`endif
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_clear();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         check("rd_valid",     rd_valid,      m_rd_valid);
         check("rd_data",      rd_data,       m_rd_data);
         check("s_axis_tready", s_axis_tready, m_tready());
         check("frames_avail", frames_avail,  m_frames());
         check("frame_ready",  frame_ready,   m_frames() != 0);
         check("fill_level",   fill_level,    m_fill());
         check("len_err",      len_err,       m_len_err);
         if (rd_valid) got_q.push_back(rd_data);
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs are set just after a rising edge and held until the next call.
   task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                        input logic r, input logic f);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      rd_en         = r;
      flush         = f;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic write_words(input logic [31:0] base, input int n, input int last_at);
      for (int i = 0; i < n; i++) cycle(1'b1, base + 32'(i), (i == last_at), 1'b0, 1'b0);
   endtask

   task automatic read_n(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic check_got(input string name, input logic [31:0] base, input int n);
      check({name, "_count"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) check(name, got_q[i], base + 32'(i));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   // ---------------- scenarios ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      check("reset_tready",   s_axis_tready, 1);
      check("reset_rd_data",  rd_data, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_frames",   frames_avail, 0);
      check("reset_fill",     fill_level, 0);
      check("reset_len_err",  len_err, 0);

      // Single frame, 1-cycle read latency
      got_q.delete();
      write_words(32'h10, 3, -1);
      check("s1_no_commit_yet", frame_ready, 0);
      write_words(32'h13, 1, 0);
      check("s1_frames", frames_avail, 1);
      check("s1_frame_ready", frame_ready, 1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("s1_lat_valid", rd_valid, 1);
      check("s1_lat_data", rd_data, 32'h10);
      read_n(3);
      idle();
      check("s1_frames_after", frames_avail, 0);
      check_got("s1_data", 32'h10, 4);

      // Partial frame is not readable
      got_q.delete();
      write_words(32'h20, 3, -1);
      idle();
      check("s2_frame_ready", frame_ready, 0);
      check("s2_fill", fill_level, 3);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("s2_no_rd_valid", rd_valid, 0);
      write_words(32'h23, 1, 0);
      idle();
      read_n(4);
      idle();
      check_got("s2_data", 32'h20, 4);

      // Full FIFO, simultaneous read and held write
      got_q.delete();
      for (int f = 0; f < 4; f++) write_words(32'h100 + 32'(4 * f), 4, 3);
      idle();
      check("s3_tready_full", s_axis_tready, 0);
      check("s3_frames", frames_avail, 4);
      check("s3_fill", fill_level, 16);
      cycle(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
      check("s3_fill_read_only", fill_level, 15);
      check("s3_frames_mid", frames_avail, 4);
      cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      check("s3_fill_write_in", fill_level, 16);
      idle();
      read_n(15);
      write_words(32'h201, 3, 2);
      idle();
      read_n(4);
      idle();
      check("s3_count", got_q.size(), 20);
      if (got_q.size() == 20) begin
         check("s3_first", got_q[0], 32'h100);
         check("s3_last_old", got_q[15], 32'h10F);
         check("s3_held_word", got_q[16], 32'h200);
         check("s3_last_new", got_q[19], 32'h203);
      end
      check("s3_frames_end", frames_avail, 0);

`ifdef IM_FIFO_TLAST_CHECK_EN
      // Early tlast rewinds and sets len_err
      got_q.delete();
      write_words(32'h30, 2, 1);
      idle();
      check("s4_len_err", len_err, 1);
      check("s4_fill", fill_level, 0);
      write_words(32'h40, 4, 3);
      idle();
      check("s4_frames", frames_avail, 1);
      read_n(4);
      idle();
      check_got("s4_data", 32'h40, 4);

      // Missing tlast: frame discarded up to the next tlast
      got_q.delete();
      write_words(32'h50, 6, -1);
      write_words(32'h56, 1, 0);
      write_words(32'h60, 4, 3);
      idle();
      check("s5_fill", fill_level, 4);
      check("s5_frames", frames_avail, 1);
      check("s5_len_err", len_err, 1);
      read_n(4);
      idle();
      check_got("s5_data", 32'h60, 4);
`else
      // tlast ignored: frames commit by count
      got_q.delete();
      write_words(32'h30, 4, 1);
      idle();
      check("s4_len_err", len_err, 0);
      check("s4_frames", frames_avail, 1);
      check("s4_fill", fill_level, 4);
      read_n(4);
      idle();
      check_got("s4_data", 32'h30, 4);

      got_q.delete();
      write_words(32'h50, 7, 6);
      write_words(32'h60, 5, 3);
      idle();
      check("s5_frames", frames_avail, 3);
      check("s5_fill", fill_level, 12);
      read_n(12);
      idle();
      check("s5_count", got_q.size(), 12);
      if (got_q.size() == 12) begin
         check("s5_w6", got_q[6], 32'h56);
         check("s5_w7", got_q[7], 32'h60);
         check("s5_w11", got_q[11], 32'h64);
      end
`endif

      // Flush with two frames stored and a read in progress
      write_words(32'h70, 4, 3);
      write_words(32'h74, 4, 3);
      read_n(2);
      cycle(1'b1, 32'h99, 1'b1, 1'b1, 1'b1);
      check("s6_rd_valid", rd_valid, 0);
      check("s6_rd_data", rd_data, 0);
      check("s6_frames", frames_avail, 0);
      check("s6_frame_ready", frame_ready, 0);
      check("s6_fill", fill_level, 0);
      check("s6_len_err", len_err, 0);
      check("s6_tready_in_flush", s_axis_tready, 0);
      idle();
      check("s6_tready_after", s_axis_tready, 1);
      got_q.delete();
      write_words(32'h80, 4, 3);
      idle();
      read_n(4);
      idle();
      check_got("s6_data", 32'h80, 4);

      // Pointer wrap over 10 frames, two frames in flight at a time
      got_q.delete();
      for (int k = 0; k < 5; k++) begin
         write_words(32'h1000 + 32'(8 * k), 4, 3);
         write_words(32'h1004 + 32'(8 * k), 4, 3);
         idle();
         read_n(8);
         idle();
      end
      check_got("s7_wrap", 32'h1000, 40);
      check("s7_fill_end", fill_level, 0);

      repeat (2) idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
